// File: rtl/upg_word_loader_pkg.sv
// Shared types and constants for the upg_* UART upgrade loader blocks.
package upg_word_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_DONE,
    ST_ERROR
  } upg_state_t;

  localparam logic [7:0] UPG_SYNC_BYTE = 8'hA5;
  localparam int         UPG_MAX_WORDS = 16384;
  localparam int         UPG_ADR_W     = 14;

  typedef logic [UPG_ADR_W-1:0] upg_adr_t;

  function automatic logic in_session(input upg_state_t s);
    return (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_DATA);
  endfunction

endpackage

// File: rtl/upg_word_loader_if.sv
// Byte-stream input and memory-write output bundle of the word loader.
interface upg_word_loader_if;
  import upg_word_loader_pkg::*;

  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        upg_wen_o;
  upg_adr_t    upg_adr_o;
  logic [31:0] upg_dat_o;
  logic        upg_done_o;
  logic        busy_o;
  logic        err_o;

  // master: byte source / memory observer; slave: the loader itself
  modport master (
    output rx_valid, rx_data,
    input  upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, busy_o, err_o
  );

  modport slave (
    input  rx_valid, rx_data,
    output upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, busy_o, err_o
  );

endinterface

// File: rtl/upg_gap_timer.sv
// Idle-gap counter: counts enabled cycles since the last clear, flags LIMIT-1 reached.
// Holds its value while disabled and saturates at the limit; clear has priority.
module upg_gap_timer #(
  parameter int LIMIT = 1000000
) (
  input  logic clock,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int             W    = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0]   LAST = W'(LIMIT - 1);

  logic [W-1:0] count;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + W'(1);
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/upg_word_loader.sv
// UART upgrade loader: SYNC, 16-bit LE word count, then LE 32-bit words written to memory.
// Write pulse lands one cycle after the 4th byte of a word; never stalls, bytes accepted every cycle.
module upg_word_loader
  import upg_word_loader_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = UPG_SYNC_BYTE,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter int         MAX_WORDS      = UPG_MAX_WORDS
) (
  input logic              clock,
  input logic              rst_n,
  upg_word_loader_if.slave bus
);

  upg_state_t  state;
  logic [15:0] len;
  logic [14:0] word_cnt;
  upg_adr_t    adr_cnt;
  logic [1:0]  byte_idx;
  logic [23:0] word_acc;
  logic        wen_r;
  upg_adr_t    adr_r;
  logic [31:0] dat_r;
  logic        done_r;
  logic        busy_r;
  logic        err_r;

  logic        accept;
  logic        sync_hit;
  logic        expired;
  logic [15:0] len_full;

  assign accept   = bus.rx_valid;
  assign sync_hit = accept && (bus.rx_data == SYNC_BYTE) && !in_session(state);
  assign len_full = {bus.rx_data, len[7:0]};

  upg_gap_timer #(.LIMIT(TIMEOUT_CYCLES)) u_gap_timer (
    .clock   (clock),
    .rst_n   (rst_n),
    .clear   (sync_hit || (accept && in_session(state))),
    .enable  (in_session(state)),
    .expired (expired)
  );

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      len      <= '0;
      word_cnt <= '0;
      adr_cnt  <= '0;
      byte_idx <= '0;
      word_acc <= '0;
      wen_r    <= 1'b0;
      adr_r    <= '0;
      dat_r    <= '0;
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      wen_r <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (sync_hit) begin
            state    <= ST_LEN_LO;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
            busy_r   <= 1'b1;
            adr_cnt  <= '0;
            word_cnt <= '0;
            byte_idx <= '0;
          end
        end
        ST_LEN_LO: begin
          if (accept) begin
            len[7:0] <= bus.rx_data;
            state    <= ST_LEN_HI;
          end else if (expired) begin
            state  <= ST_ERROR;
            err_r  <= 1'b1;
            busy_r <= 1'b0;
          end
        end
        ST_LEN_HI: begin
          if (accept) begin
            len[15:8] <= bus.rx_data;
            if (len_full == 16'd0) begin
              state  <= ST_DONE;
              done_r <= 1'b1;
              busy_r <= 1'b0;
            end else if (len_full > 16'(MAX_WORDS)) begin
              state  <= ST_ERROR;
              err_r  <= 1'b1;
              busy_r <= 1'b0;
            end else begin
              state <= ST_DATA;
            end
          end else if (expired) begin
            state  <= ST_ERROR;
            err_r  <= 1'b1;
            busy_r <= 1'b0;
          end
        end
        ST_DATA: begin
          // word_cnt reaches len on the byte-3 edge, so DONE lands one cycle after the last pulse
          if ({1'b0, word_cnt} == len) begin
            state  <= ST_DONE;
            done_r <= 1'b1;
            busy_r <= 1'b0;
          end else if (accept) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: word_acc[7:0]   <= bus.rx_data;
              2'd1: word_acc[15:8]  <= bus.rx_data;
              2'd2: word_acc[23:16] <= bus.rx_data;
              default: begin
                wen_r    <= 1'b1;
                adr_r    <= adr_cnt;
                dat_r    <= {bus.rx_data, word_acc};
                adr_cnt  <= adr_cnt + upg_adr_t'(1);
                word_cnt <= word_cnt + 15'd1;
              end
            endcase
          end else if (expired) begin
            state  <= ST_ERROR;
            err_r  <= 1'b1;
            busy_r <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.upg_wen_o  = wen_r;
  assign bus.upg_adr_o  = adr_r;
  assign bus.upg_dat_o  = dat_r;
  assign bus.upg_done_o = done_r;
  assign bus.busy_o     = busy_r;
  assign bus.err_o      = err_r;

endmodule

// File: tb/tb_upg_word_loader.sv
// Bench for upg_word_loader: directed sessions plus randomized images against a payload-level model.
module tb_upg_word_loader;
  import upg_word_loader_pkg::*;

  typedef struct packed {
    logic [13:0] adr;
    logic [31:0] dat;
  } wr_t;

  logic clock = 1'b0;
  logic rst_n = 1'b0;

  upg_word_loader_if ifc();

  upg_word_loader #(.TIMEOUT_CYCLES(100)) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  always #5 clock = ~clock;

  wr_t        obs_q[$];
  wr_t        exp_q[$];
  logic [7:0] stim[$];
  int         passed = 0;
  int         total = 0;
  int         wen_multi = 0;
  logic       prev_wen = 1'b0;

  always @(negedge clock) begin
    if (ifc.upg_wen_o === 1'b1) obs_q.push_back({ifc.upg_adr_o, ifc.upg_dat_o});
    if (ifc.upg_wen_o === 1'b1 && prev_wen === 1'b1) wen_multi++;
    prev_wen = ifc.upg_wen_o;
  end

  task automatic cyc(input logic v, input logic [7:0] d);
    ifc.rx_valid = v;
    ifc.rx_data  = d;
    @(posedge clock);
    #1;
    ifc.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 8'h00);
  endtask

  task automatic send_stim(input int gap_max);
    foreach (stim[i]) begin
      idle($urandom_range(gap_max, 0));
      cyc(1'b1, stim[i]);
    end
    stim.delete();
  endtask

  // Reference: a session is SYNC, count LE, then 4 bytes per word LE, word i at address i
  task automatic build_image(input int nwords);
    logic [15:0] n16;
    logic [31:0] word;
    logic [7:0]  b;
    n16 = 16'(nwords);
    stim.push_back(8'hA5);
    stim.push_back(n16[7:0]);
    stim.push_back(n16[15:8]);
    for (int w = 0; w < nwords; w++) begin
      word = 32'd0;
      for (int k = 0; k < 4; k++) begin
        b = 8'($urandom);
        stim.push_back(b);
        word = word + (32'(b) << (8 * k));
      end
      exp_q.push_back({14'(w), word});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ifc.rx_valid = 1'b0;
    ifc.rx_data  = 8'h00;
    #12;
    total++;
    if ({ifc.upg_wen_o, ifc.upg_adr_o, ifc.upg_dat_o, ifc.upg_done_o, ifc.busy_o, ifc.err_o} !== '0)
      $display("FAIL reset_outputs: got wen=%b adr=%h dat=%h done=%b busy=%b err=%b, want all 0",
               ifc.upg_wen_o, ifc.upg_adr_o, ifc.upg_dat_o, ifc.upg_done_o, ifc.busy_o, ifc.err_o);
    else passed++;
    @(negedge clock) rst_n = 1'b1;
    @(posedge clock);
    #1;
    cyc(1'b1, 8'h3C);
    total++;
    if (ifc.busy_o !== 1'b0) $display("FAIL idle_ignores_non_sync: busy=%b want 0", ifc.busy_o);
    else passed++;
  endtask

  task automatic test_two_words();
    obs_q.delete();
    stim = {8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_stim(0);
    total++;
    if ({ifc.upg_wen_o, ifc.upg_adr_o, ifc.upg_dat_o, ifc.upg_done_o} !== {1'b1, 14'd1, 32'hDEADBEEF, 1'b0})
      $display("FAIL two_words_pulse: wen=%b adr=%h dat=%h done=%b want 1/0001/deadbeef/0",
               ifc.upg_wen_o, ifc.upg_adr_o, ifc.upg_dat_o, ifc.upg_done_o);
    else passed++;
    idle(1);
    total++;
    if ({ifc.upg_wen_o, ifc.upg_done_o, ifc.busy_o, ifc.err_o} !== 4'b0100)
      $display("FAIL two_words_done: wen=%b done=%b busy=%b err=%b want 0/1/0/0",
               ifc.upg_wen_o, ifc.upg_done_o, ifc.busy_o, ifc.err_o);
    else passed++;
    exp_q = {wr_t'({14'd0, 32'h12345678}), wr_t'({14'd1, 32'hDEADBEEF})};
    total++;
    if (obs_q.size() != exp_q.size()) $display("FAIL two_words_count: got %0d writes want %0d", obs_q.size(), exp_q.size());
    else passed++;
    foreach (exp_q[i]) begin
      total++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) $display("FAIL two_words_write%0d: want %h", i, exp_q[i]);
      else passed++;
    end
    exp_q.delete();
  endtask

  task automatic test_zero_len();
    obs_q.delete();
    stim = {8'hA5, 8'h00, 8'h00};
    send_stim(0);
    total++;
    if ({ifc.upg_done_o, ifc.busy_o, ifc.err_o} !== 3'b100)
      $display("FAIL zero_len_state: done=%b busy=%b err=%b want 1/0/0", ifc.upg_done_o, ifc.busy_o, ifc.err_o);
    else passed++;
    idle(3);
    total++;
    if (obs_q.size() != 0) $display("FAIL zero_len_writes: got %0d writes want 0", obs_q.size());
    else passed++;
  endtask

  task automatic test_too_long();
    obs_q.delete();
    stim = {8'hA5, 8'h01, 8'h41};
    send_stim(0);
    total++;
    if ({ifc.err_o, ifc.busy_o, ifc.upg_done_o} !== 3'b100)
      $display("FAIL len_16641_err: err=%b busy=%b done=%b want 1/0/0", ifc.err_o, ifc.busy_o, ifc.upg_done_o);
    else passed++;
    stim = {8'hA5, 8'h01, 8'h40};
    send_stim(1);
    total++;
    if (ifc.err_o !== 1'b1) $display("FAIL len_16385_err: err=%b want 1", ifc.err_o);
    else passed++;
    stim = {8'hA5, 8'h00, 8'h40};
    send_stim(0);
    total++;
    if ({ifc.err_o, ifc.busy_o} !== 2'b01) $display("FAIL len_16384_accepted: err=%b busy=%b want 0/1", ifc.err_o, ifc.busy_o);
    else passed++;
    idle(100);
    total++;
    if (ifc.err_o !== 1'b1) $display("FAIL data_timeout_no_bytes: err=%b want 1", ifc.err_o);
    else passed++;
    exp_q.delete();
    build_image(1);
    send_stim(2);
    idle(1);
    total++;
    if ({ifc.upg_done_o, ifc.err_o, ifc.busy_o} !== 3'b100)
      $display("FAIL recover_session: done=%b err=%b busy=%b want 1/0/0", ifc.upg_done_o, ifc.err_o, ifc.busy_o);
    else passed++;
    total++;
    if (obs_q.size() != 1 || obs_q[0] !== exp_q[0])
      $display("FAIL recover_write: got %0d writes, want one write %h", obs_q.size(), exp_q[0]);
    else passed++;
    exp_q.delete();
  endtask

  task automatic test_timeout();
    obs_q.delete();
    stim = {8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
    send_stim(0);
    idle(99);
    total++;
    if ({ifc.err_o, ifc.busy_o} !== 2'b01) $display("FAIL timeout_early: cycle 99 err=%b busy=%b want 0/1", ifc.err_o, ifc.busy_o);
    else passed++;
    idle(1);
    total++;
    if ({ifc.err_o, ifc.busy_o} !== 2'b10) $display("FAIL timeout_at_100: err=%b busy=%b want 1/0", ifc.err_o, ifc.busy_o);
    else passed++;
    idle(3);
    total++;
    if (obs_q.size() != 0) $display("FAIL timeout_partial_write: got %0d writes want 0", obs_q.size());
    else passed++;
  endtask

  task automatic test_reset_mid();
    obs_q.delete();
    stim = {8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03};
    send_stim(0);
    cyc(1'b1, 8'h04);
    rst_n = 1'b0;
    #2;
    total++;
    if ({ifc.upg_wen_o, ifc.upg_adr_o, ifc.upg_dat_o, ifc.upg_done_o, ifc.busy_o, ifc.err_o} !== '0)
      $display("FAIL reset_mid_outputs: wen=%b adr=%h dat=%h done=%b busy=%b err=%b want all 0",
               ifc.upg_wen_o, ifc.upg_adr_o, ifc.upg_dat_o, ifc.upg_done_o, ifc.busy_o, ifc.err_o);
    else passed++;
    idle(2);
    @(negedge clock) rst_n = 1'b1;
    @(posedge clock);
    #1;
    total++;
    if (obs_q.size() != 0) $display("FAIL reset_mid_no_pulse: got %0d writes want 0", obs_q.size());
    else passed++;
    cyc(1'b1, 8'h55);
    total++;
    if (ifc.busy_o !== 1'b0) $display("FAIL reset_mid_55_ignored: busy=%b want 0", ifc.busy_o);
    else passed++;
    cyc(1'b1, 8'hA5);
    total++;
    if (ifc.busy_o !== 1'b1) $display("FAIL reset_mid_sync_starts: busy=%b want 1", ifc.busy_o);
    else passed++;
    idle(100);
  endtask

  task automatic test_images(input int sessions, input int gap_max, input int fixed_len);
    int n;
    for (int s = 0; s < sessions; s++) begin
      obs_q.delete();
      exp_q.delete();
      n = (fixed_len > 0) ? fixed_len : int'($urandom_range(5, 1));
      build_image(n);
      send_stim(gap_max);
      total++;
      if ({ifc.upg_wen_o, ifc.upg_done_o, ifc.busy_o} !== 3'b101)
        $display("FAIL image%0d_last_pulse: wen=%b done=%b busy=%b want 1/0/1", s, ifc.upg_wen_o, ifc.upg_done_o, ifc.busy_o);
      else passed++;
      idle(1);
      total++;
      if ({ifc.upg_done_o, ifc.busy_o, ifc.err_o} !== 3'b100)
        $display("FAIL image%0d_done: done=%b busy=%b err=%b want 1/0/0", s, ifc.upg_done_o, ifc.busy_o, ifc.err_o);
      else passed++;
      total++;
      if (obs_q.size() != exp_q.size()) $display("FAIL image%0d_count: got %0d writes want %0d", s, obs_q.size(), exp_q.size());
      else passed++;
      foreach (exp_q[i]) begin
        total++;
        if (i >= obs_q.size() || obs_q[i] !== exp_q[i])
          $display("FAIL image%0d_write%0d: got %h want %h", s, i, (i < obs_q.size()) ? obs_q[i] : wr_t'('x), exp_q[i]);
        else passed++;
      end
    end
  endtask

  task automatic test_back_to_back();
    test_images(1, 0, 3);
  endtask

  task automatic test_random();
    test_images(5, 3, 0);
    total++;
    if (wen_multi != 0) $display("FAIL wen_single_cycle: %0d multi-cycle pulses want 0", wen_multi);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_zero_len();
    test_too_long();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
